ex_mem: RTL and testbench

EX_MEM -- requirements
Module: ex_mem

---
 rtl/ex_mem_pkg.sv | 37 +++
 rtl/ex_mem.sv | 115 +++++++++++
 tb/tb_ex_mem.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_pkg.sv
// Shared pipeline widths and constants for the EX/MEM stage register.
// Also holds the per-edge action decode used by ex_mem.
package ex_mem_pkg;

  localparam int unsigned RegBus       = 32;
  localparam int unsigned RegAddrBus   = 5;
  localparam int unsigned DoubleRegBus = 64;

  localparam logic            RstEnable    = 1'b1;
  localparam logic            WriteEnable  = 1'b1;
  localparam logic            WriteDisable = 1'b0;
  localparam logic            Stop         = 1'b1;
  localparam logic            NoStop       = 1'b0;
  localparam logic [31:0]     ZeroWord     = 32'h0000_0000;

  typedef enum logic [1:0] {
    ACT_FLUSH  = 2'd0,
    ACT_BUBBLE = 2'd1,
    ACT_PASS   = 2'd2,
    ACT_HOLD   = 2'd3
  } ex_mem_act_e;

  // EX stalled with MEM free inserts a bubble; both stalled freezes the stage.
  function automatic ex_mem_act_e decode_action(input logic flush,
                                                input logic stall_ex,
                                                input logic stall_mem);
    if (flush == WriteEnable)
      return ACT_FLUSH;
    else if (stall_ex == NoStop)
      return ACT_PASS;
    else if (stall_mem == NoStop)
      return ACT_BUBBLE;
    else
      return ACT_HOLD;
  endfunction

endpackage

// File: rtl/ex_mem.sv
// EX/MEM pipeline register with flush/bubble/pass/hold control.
// Multiply-accumulate feedback (hilo_o/cnt_o) exists only with EX_MEM_MADD_EN.
module ex_mem
  import ex_mem_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [5:0]              stall,
  input  logic                    flush,
  input  logic [RegAddrBus-1:0]   ex_wd,
  input  logic                    ex_wreg,
  input  logic [RegBus-1:0]       ex_wdata,
  input  logic [RegBus-1:0]       ex_hi,
  input  logic [RegBus-1:0]       ex_lo,
  input  logic                    ex_whilo,
  input  logic [DoubleRegBus-1:0] hilo_i,
  input  logic [1:0]              cnt_i,
  output logic [RegAddrBus-1:0]   mem_wd,
  output logic                    mem_wreg,
  output logic [RegBus-1:0]       mem_wdata,
  output logic [RegBus-1:0]       mem_hi,
  output logic [RegBus-1:0]       mem_lo,
  output logic                    mem_whilo,
  output logic [DoubleRegBus-1:0] hilo_o,
  output logic [1:0]              cnt_o
);

  ex_mem_act_e w_act;

  logic [RegAddrBus-1:0] r_wd;
  logic                  r_wreg;
  logic [RegBus-1:0]     r_wdata;
  logic [RegBus-1:0]     r_hi;
  logic [RegBus-1:0]     r_lo;
  logic                  r_whilo;

  assign w_act = decode_action(flush, stall[3], stall[4]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      r_wd    <= '0;
      r_wreg  <= WriteDisable;
      r_wdata <= ZeroWord;
      r_hi    <= ZeroWord;
      r_lo    <= ZeroWord;
      r_whilo <= WriteDisable;
    end else begin
      case (w_act)
        ACT_FLUSH, ACT_BUBBLE: begin
          r_wd    <= '0;
          r_wreg  <= WriteDisable;
          r_wdata <= ZeroWord;
          r_hi    <= ZeroWord;
          r_lo    <= ZeroWord;
          r_whilo <= WriteDisable;
        end
        ACT_PASS: begin
          r_wd    <= ex_wd;
          r_wreg  <= ex_wreg;
          r_wdata <= ex_wdata;
          r_hi    <= ex_hi;
          r_lo    <= ex_lo;
          r_whilo <= ex_whilo;
        end
        ACT_HOLD: ;
        default: ;
      endcase
    end
  end

  assign mem_wd    = r_wd;
  assign mem_wreg  = r_wreg;
  assign mem_wdata = r_wdata;
  assign mem_hi    = r_hi;
  assign mem_lo    = r_lo;
  assign mem_whilo = r_whilo;

`ifdef EX_MEM_MADD_EN
  logic [DoubleRegBus-1:0] r_hilo;
  logic [1:0]              r_cnt;
  logic                    w_unused_bits;

  // Partial product survives only while EX is held with a bubble downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      r_hilo <= '0;
      r_cnt  <= '0;
    end else begin
      case (w_act)
        ACT_FLUSH, ACT_PASS: begin
          r_hilo <= '0;
          r_cnt  <= '0;
        end
        ACT_BUBBLE: begin
          r_hilo <= hilo_i;
          r_cnt  <= cnt_i;
        end
        ACT_HOLD: ;
        default: ;
      endcase
    end
  end

  assign hilo_o        = r_hilo;
  assign cnt_o         = r_cnt;
  assign w_unused_bits = ^{stall[5], stall[2:0]};
`else
  logic w_unused_bits;

  assign hilo_o        = '0;
  assign cnt_o         = '0;
  assign w_unused_bits = ^{hilo_i, cnt_i, stall[5], stall[2:0]};
`endif

endmodule

// File: tb/tb_ex_mem.sv
// Self-checking bench for ex_mem: directed vector table, reset corners and
// randomized traffic against a rule-level reference model.
module tb_ex_mem;

`ifdef EX_MEM_MADD_EN
  localparam bit MADD = 1'b1;
`else
  localparam bit MADD = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic [31:0] ex_hi;
  logic [31:0] ex_lo;
  logic        ex_whilo;
  logic [63:0] hilo_i;
  logic [1:0]  cnt_i;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic        mem_whilo;
  logic [63:0] hilo_o;
  logic [1:0]  cnt_o;

  ex_mem dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .flush     (flush),
    .ex_wd     (ex_wd),
    .ex_wreg   (ex_wreg),
    .ex_wdata  (ex_wdata),
    .ex_hi     (ex_hi),
    .ex_lo     (ex_lo),
    .ex_whilo  (ex_whilo),
    .hilo_i    (hilo_i),
    .cnt_i     (cnt_i),
    .mem_wd    (mem_wd),
    .mem_wreg  (mem_wreg),
    .mem_wdata (mem_wdata),
    .mem_hi    (mem_hi),
    .mem_lo    (mem_lo),
    .mem_whilo (mem_whilo),
    .hilo_o    (hilo_o),
    .cnt_o     (cnt_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned n_checks;
  int unsigned n_errors;

  // Reference model state: what each output should hold.
  logic [4:0]  m_wd;
  logic        m_wreg;
  logic [31:0] m_wdata;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic        m_whilo;
  logic [63:0] m_hilo;
  logic [1:0]  m_cnt;

  typedef struct {
    logic        flush;
    logic [5:0]  stall;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic        whilo;
    logic [63:0] hilo;
    logic [1:0]  cnt;
    logic [4:0]  e_wd;
    logic        e_wreg;
    logic [31:0] e_wdata;
    logic [31:0] e_hi;
    logic        e_whilo;
    logic [63:0] e_hilo;
    logic [1:0]  e_cnt;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [191:0] dut_vec();
    return {23'd0, mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, hilo_o, cnt_o};
  endfunction

  function automatic logic [191:0] model_vec();
    return {23'd0, m_wd, m_wreg, m_wdata, m_hi, m_lo, m_whilo, m_hilo, m_cnt};
  endfunction

  task automatic model_reset();
    m_wd = '0; m_wreg = 1'b0; m_wdata = '0; m_hi = '0;
    m_lo = '0; m_whilo = 1'b0; m_hilo = '0; m_cnt = '0;
  endtask

  task automatic model_edge();
    if (flush) begin
      model_reset();
    end else if (!stall[3]) begin
      m_wd = ex_wd; m_wreg = ex_wreg; m_wdata = ex_wdata;
      m_hi = ex_hi; m_lo = ex_lo; m_whilo = ex_whilo;
      m_hilo = '0; m_cnt = '0;
    end else if (!stall[4]) begin
      m_wd = '0; m_wreg = 1'b0; m_wdata = '0;
      m_hi = '0; m_lo = '0; m_whilo = 1'b0;
      m_hilo = MADD ? hilo_i : 64'd0;
      m_cnt  = MADD ? cnt_i : 2'd0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input vec_t v);
    flush = v.flush; stall = v.stall; ex_wd = v.wd; ex_wreg = v.wreg;
    ex_wdata = v.wdata; ex_hi = v.hi; ex_lo = 32'h0; ex_whilo = v.whilo;
    hilo_i = v.hilo; cnt_i = v.cnt;
  endtask

  function automatic vec_t mk(input logic fl, input logic [5:0] st, input logic [4:0] wd,
                              input logic wr, input logic [31:0] wdat, input logic [31:0] hi,
                              input logic wh, input logic [63:0] hl, input logic [1:0] cn,
                              input logic [4:0] ewd, input logic ewr, input logic [31:0] ewdat,
                              input logic [31:0] ehi, input logic ewh, input logic [63:0] ehl,
                              input logic [1:0] ecn);
    vec_t v;
    v.flush = fl; v.stall = st; v.wd = wd; v.wreg = wr; v.wdata = wdat; v.hi = hi;
    v.whilo = wh; v.hilo = hl; v.cnt = cn;
    v.e_wd = ewd; v.e_wreg = ewr; v.e_wdata = ewdat; v.e_hi = ehi; v.e_whilo = ewh;
    v.e_hilo = ehl; v.e_cnt = ecn;
    return v;
  endfunction

  initial begin
    logic [63:0] hl_a;
    logic [63:0] hl_b;
    n_checks = 0;
    n_errors = 0;
    hl_a = MADD ? 64'h0000_0001_FFFF_FFFF : 64'd0;
    hl_b = MADD ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd0;

    //            fl  stall      wd  wr wdata         hi     wh hilo                    cnt  | ewd ewr ewdata        ehi    ewh ehilo ecnt
    tbl[0]  = mk(0, 6'b000000,  5, 1, 32'hDEADBEEF, 32'h0,  0, 64'h1234,              2'd2,  5, 1, 32'hDEADBEEF, 32'h0,  0, 64'd0, 2'd0);
    tbl[1]  = mk(0, 6'b001111,  6, 1, 32'h1234,     32'h9,  1, 64'h0000_0001_FFFF_FFFF, 2'd1, 0, 0, 32'h0,       32'h0,  0, hl_a, MADD ? 2'd1 : 2'd0);
    tbl[2]  = mk(0, 6'b000000,  3, 0, 32'hA5A5A5A5, 32'h11, 1, 64'h55,                2'd3,  3, 0, 32'hA5A5A5A5, 32'h11, 1, 64'd0, 2'd0);
    tbl[3]  = mk(0, 6'b011111,  7, 1, 32'h1,        32'h22, 0, 64'hABC,               2'd2,  3, 0, 32'hA5A5A5A5, 32'h11, 1, 64'd0, 2'd0);
    tbl[4]  = tbl[3];
    tbl[5]  = tbl[3];
    tbl[6]  = mk(1, 6'b011111,  8, 1, 32'h55,       32'h7,  1, 64'h77,                2'd3,  0, 0, 32'h0,       32'h0,  0, 64'd0, 2'd0);
    tbl[7]  = mk(0, 6'b100111,  9, 1, 32'h0BADF00D, 32'h33, 1, 64'h1,                 2'd1,  9, 1, 32'h0BADF00D, 32'h33, 1, 64'd0, 2'd0);
    tbl[8]  = mk(0, 6'b101000, 10, 1, 32'hFFFF,     32'h44, 1, 64'hFFFF_FFFF_FFFF_FFFF, 2'd3, 0, 0, 32'h0,       32'h0,  0, hl_b, MADD ? 2'd3 : 2'd0);
    tbl[9]  = mk(0, 6'b111000, 11, 1, 32'h77,       32'h55, 1, 64'h2,                 2'd2,  0, 0, 32'h0,       32'h0,  0, hl_b, MADD ? 2'd3 : 2'd0);
    tbl[10] = mk(0, 6'b000000, 12, 1, 32'h1,        32'h2,  0, 64'h5,                 2'd1, 12, 1, 32'h1,       32'h2,  0, 64'd0, 2'd0);

    rst = 1'b1;
    drive(mk(0, 6'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    model_reset();
    #2;
    chk("reset_state", dut_vec(), model_vec());
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i]);
      step();
      chk($sformatf("vec%0d_wd", i),    {187'd0, mem_wd},    {187'd0, tbl[i].e_wd});
      chk($sformatf("vec%0d_wreg", i),  {191'd0, mem_wreg},  {191'd0, tbl[i].e_wreg});
      chk($sformatf("vec%0d_wdata", i), {160'd0, mem_wdata}, {160'd0, tbl[i].e_wdata});
      chk($sformatf("vec%0d_hi", i),    {160'd0, mem_hi},    {160'd0, tbl[i].e_hi});
      chk($sformatf("vec%0d_whilo", i), {191'd0, mem_whilo}, {191'd0, tbl[i].e_whilo});
      chk($sformatf("vec%0d_hilo", i),  {128'd0, hilo_o},    {128'd0, tbl[i].e_hilo});
      chk($sformatf("vec%0d_cnt", i),   {190'd0, cnt_o},     {190'd0, tbl[i].e_cnt});
      chk($sformatf("vec%0d_model", i), dut_vec(), model_vec());
    end

    // Asynchronous reset between edges with live data in the stage.
    drive(mk(0, 6'd0, 4, 1, 32'h1234, 32'h3, 1, 64'h9, 2'd1, 0, 0, 0, 0, 0, 0, 0));
    step();
    chk("rst_pre_wdata", {160'd0, mem_wdata}, {160'd0, 32'h1234});
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_async_all", dut_vec(), {192'd0});
    #1;
    rst = 1'b0;

    // Reset in the middle of an accumulate, then a hold edge keeps zeros.
    drive(mk(0, 6'b001000, 1, 1, 32'h9, 32'h1, 1, 64'hCAFE_F00D_0000_0001, 2'd2, 0, 0, 0, 0, 0, 0, 0));
    step();
    chk("madd_loaded", {128'd0, hilo_o}, {128'd0, (MADD ? 64'hCAFE_F00D_0000_0001 : 64'd0)});
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("madd_rst_discard", {126'd0, hilo_o, cnt_o}, {192'd0});
    #1;
    rst = 1'b0;
    drive(mk(0, 6'b011000, 2, 1, 32'h8, 32'h1, 1, 64'h3, 2'd3, 0, 0, 0, 0, 0, 0, 0));
    step();
    chk("hold_after_rst", dut_vec(), {192'd0});

    // Randomized traffic against the model, with occasional mid-cycle resets.
    for (int n = 0; n < 400; n++) begin
      flush    = ($urandom_range(0, 7) == 0);
      stall    = 6'($urandom);
      ex_wd    = 5'($urandom);
      ex_wreg  = 1'($urandom);
      ex_wdata = $urandom;
      ex_hi    = $urandom;
      ex_lo    = $urandom;
      ex_whilo = 1'($urandom);
      hilo_i   = {$urandom, $urandom};
      cnt_i    = 2'($urandom);
      step();
      chk($sformatf("rand%0d", n), dut_vec(), model_vec());
      if ($urandom_range(0, 49) == 0) begin
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk($sformatf("rand%0d_rst", n), dut_vec(), model_vec());
        #1;
        rst = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
